// File: rtl/alu_rsv_station_pkg.sv
// Shared types and constants for the ALU reservation station.
// Optional feature: RS_AGE_SEL_EN selects oldest-first issue (see rs_select).
package alu_rs_pkg;

   // Default widths; the station's TAG_W/XLEN parameters default to these
   // and the entry struct below is laid out with them.
   localparam int DEF_TAG_W = 6;
   localparam int DEF_XLEN  = 32;

   // ALU extension codes carried alongside funct3
   localparam logic [2:0] ALU_EXT_R      = 3'd0;
   localparam logic [2:0] ALU_EXT_JAL    = 3'd1;
   localparam logic [2:0] ALU_EXT_JALR   = 3'd2;
   localparam logic [2:0] ALU_EXT_BRANCH = 3'd3;
   localparam logic [2:0] ALU_EXT_SUB    = 3'd4;
   localparam logic [2:0] ALU_EXT_UPPER  = 3'd5;

   typedef struct packed {
      logic                 valid;
      logic                 op1_rdy;
      logic [DEF_TAG_W-1:0] op1_tag;
      logic [DEF_XLEN-1:0]  op1_val;
      logic                 op2_rdy;
      logic [DEF_TAG_W-1:0] op2_tag;
      logic [DEF_XLEN-1:0]  op2_val;
      logic [2:0]           funct3;
      logic [2:0]           alu_ext;
      logic [DEF_TAG_W-1:0] dest_tag;
   } rs_entry_t;

   // A broadcast matches a waiting operand on a full-width tag compare.
   function automatic logic tag_hit(input logic                 cdb_vld,
                                    input logic [DEF_TAG_W-1:0] wait_tag,
                                    input logic [DEF_TAG_W-1:0] cdb_tag);
      return cdb_vld && (wait_tag == cdb_tag);
   endfunction

endpackage

// File: rtl/alu_rsv_station_if.sv
// Dispatch / CDB / issue bundle of the ALU reservation station.
// master = dispatch, CDB and arbiter side; slave = the station itself.
interface alu_rsv_station_if #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6,
   parameter int XLEN  = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             flush;
   logic             disp_valid;
   logic             disp_ready;
   logic             disp_op1_rdy;
   logic [TAG_W-1:0] disp_op1_tag;
   logic [XLEN-1:0]  disp_op1_val;
   logic             disp_op2_rdy;
   logic [TAG_W-1:0] disp_op2_tag;
   logic [XLEN-1:0]  disp_op2_val;
   logic [2:0]       disp_funct3;
   logic [2:0]       disp_alu_ext;
   logic [TAG_W-1:0] disp_dest_tag;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_data;
   logic             iss_stall;
   logic [XLEN-1:0]  iss_op1;
   logic [XLEN-1:0]  iss_op2;
   logic [2:0]       iss_funct3;
   logic [2:0]       iss_alu_ext;
   logic [TAG_W-1:0] iss_tag;
   logic             iss_tag_valid;
   logic [CNT_W-1:0] count;

   modport master (
      output flush, disp_valid, disp_op1_rdy, disp_op1_tag, disp_op1_val,
             disp_op2_rdy, disp_op2_tag, disp_op2_val, disp_funct3,
             disp_alu_ext, disp_dest_tag, cdb_valid, cdb_tag, cdb_data,
             iss_stall,
      input  disp_ready, iss_op1, iss_op2, iss_funct3, iss_alu_ext, iss_tag,
             iss_tag_valid, count
   );

   modport slave (
      input  flush, disp_valid, disp_op1_rdy, disp_op1_tag, disp_op1_val,
             disp_op2_rdy, disp_op2_tag, disp_op2_val, disp_funct3,
             disp_alu_ext, disp_dest_tag, cdb_valid, cdb_tag, cdb_data,
             iss_stall,
      output disp_ready, iss_op1, iss_op2, iss_funct3, iss_alu_ext, iss_tag,
             iss_tag_valid, count
   );
endinterface

// File: rtl/alu_rsv_station_select.sv
// Issue select: eligibility vector -> one-hot grant.
// RS_AGE_SEL_EN defined: oldest eligible entry wins via an age matrix
// (age_q[i][j]=1 means entry i is older than entry j).
// Undefined: lowest-index eligible entry wins.
module rs_select #(
   parameter int DEPTH = 4
) (
`ifdef RS_AGE_SEL_EN
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] alloc_i,
   input  logic [DEPTH-1:0] valid_i,
`endif
   input  logic [DEPTH-1:0] elig_i,
   output logic [DEPTH-1:0] grant_o,
   output logic             grant_vld_o
);

   assign grant_vld_o = |elig_i;

`ifdef RS_AGE_SEL_EN
   logic [DEPTH-1:0] age_q [DEPTH];
   logic [DEPTH-1:0] age_d [DEPTH];

   // A new entry is younger than everything already resident.
   always_comb begin
      age_d = age_q;
      for (int k = 0; k < DEPTH; k++) begin
         if (alloc_i[k]) begin
            age_d[k] = '0;
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_i[i]) age_d[i][k] = 1'b1;
            end
         end
      end
   end

   // Age matrix register.
   always_ff @(posedge clk) begin
      if (rst) age_q <= '{default: '0};
      else     age_q <= age_d;
   end

   // Grant the eligible entry that no other eligible entry is older than.
   always_comb begin
      grant_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant_o[i] = elig_i[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && elig_i[j] && age_q[j][i]) grant_o[i] = 1'b0;
         end
      end
   end
`else
   // Grant the lowest-index eligible entry.
   always_comb begin
      grant_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (elig_i[i] && grant_o == '0) grant_o[i] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/alu_rsv_station.sv
// Reservation station and issue register for the integer ALU.
// Holds DEPTH micro-ops, wakes operands from the CDB, issues one
// operand-complete entry per unstalled cycle into a registered stage.
// Optional macro RS_AGE_SEL_EN: oldest-first select instead of lowest index.
// TAG_W/XLEN must stay equal to the package defaults (entry struct layout).
module alu_rsv_station
   import alu_rs_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = DEF_TAG_W,
   parameter int XLEN  = DEF_XLEN
) (
   input logic               clk,
   input logic               rst,
   alu_rsv_station_if.slave  bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   rs_entry_t        ent_q [DEPTH];
   rs_entry_t        ent_d [DEPTH];
   rs_entry_t        disp_e;
   rs_entry_t        sel_e;
   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] elig;
   logic [DEPTH-1:0] alloc;
   logic [DEPTH-1:0] grant;
   logic             grant_vld;
   logic [CNT_W-1:0] cnt;
   logic             disp_rdy;
   logic             do_disp;

   logic             iss_vld_q, iss_vld_d;
   logic [XLEN-1:0]  iss_op1_q, iss_op1_d;
   logic [XLEN-1:0]  iss_op2_q, iss_op2_d;
   logic [2:0]       iss_f3_q,  iss_f3_d;
   logic [2:0]       iss_ext_q, iss_ext_d;
   logic [TAG_W-1:0] iss_tag_q, iss_tag_d;

   // Occupancy, lowest free slot and eligibility from registered state only.
   always_comb begin
      cnt   = '0;
      alloc = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = ent_q[i].valid;
         elig[i]      = ent_q[i].valid && ent_q[i].op1_rdy && ent_q[i].op2_rdy;
         if (ent_q[i].valid) cnt = cnt + CNT_W'(1);
         if (!ent_q[i].valid && alloc == '0) alloc[i] = 1'b1;
      end
   end

   assign disp_rdy       = (cnt < CNT_W'(DEPTH));
   assign do_disp        = bus.disp_valid && disp_rdy && !bus.flush;
   assign bus.disp_ready = disp_rdy;
   assign bus.count      = cnt;

   rs_select #(.DEPTH(DEPTH)) u_select (
`ifdef RS_AGE_SEL_EN
      .clk         (clk),
      .rst         (rst),
      .alloc_i     (alloc & {DEPTH{do_disp}}),
      .valid_i     (valid_vec),
`endif
      .elig_i      (elig),
      .grant_o     (grant),
      .grant_vld_o (grant_vld)
   );

   // Incoming entry, capturing a same-cycle CDB broadcast for waiting operands.
   always_comb begin
      disp_e          = '0;
      disp_e.valid    = 1'b1;
      disp_e.op1_tag  = bus.disp_op1_tag;
      disp_e.op2_tag  = bus.disp_op2_tag;
      disp_e.op1_rdy  = bus.disp_op1_rdy ||
                        tag_hit(bus.cdb_valid, bus.disp_op1_tag, bus.cdb_tag);
      disp_e.op2_rdy  = bus.disp_op2_rdy ||
                        tag_hit(bus.cdb_valid, bus.disp_op2_tag, bus.cdb_tag);
      disp_e.op1_val  = bus.disp_op1_rdy ? bus.disp_op1_val : bus.cdb_data;
      disp_e.op2_val  = bus.disp_op2_rdy ? bus.disp_op2_val : bus.cdb_data;
      disp_e.funct3   = bus.disp_funct3;
      disp_e.alu_ext  = bus.disp_alu_ext;
      disp_e.dest_tag = bus.disp_dest_tag;
   end

   // Entry next state: wakeup, free on issue, dispatch write, flush last.
   always_comb begin
      ent_d = ent_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid && !ent_q[i].op1_rdy &&
             tag_hit(bus.cdb_valid, ent_q[i].op1_tag, bus.cdb_tag)) begin
            ent_d[i].op1_rdy = 1'b1;
            ent_d[i].op1_val = bus.cdb_data;
         end
         if (ent_q[i].valid && !ent_q[i].op2_rdy &&
             tag_hit(bus.cdb_valid, ent_q[i].op2_tag, bus.cdb_tag)) begin
            ent_d[i].op2_rdy = 1'b1;
            ent_d[i].op2_val = bus.cdb_data;
         end
         if (!bus.iss_stall && grant[i]) ent_d[i].valid = 1'b0;
         if (do_disp && alloc[i])        ent_d[i]       = disp_e;
         if (bus.flush)                  ent_d[i].valid = 1'b0;
      end
   end

   // Entry storage; only the valid bits need a reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
      end else begin
         ent_q <= ent_d;
      end
   end

   // One-hot mux of the granted entry.
   always_comb begin
      sel_e = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) sel_e = ent_q[i];
      end
   end

   // Issue register next state: hold while stalled, load or bubble otherwise.
   always_comb begin
      iss_vld_d = iss_vld_q;
      iss_op1_d = iss_op1_q;
      iss_op2_d = iss_op2_q;
      iss_f3_d  = iss_f3_q;
      iss_ext_d = iss_ext_q;
      iss_tag_d = iss_tag_q;
      if (bus.flush) begin
         iss_vld_d = 1'b0;
      end else if (!bus.iss_stall) begin
         iss_vld_d = grant_vld;
         if (grant_vld) begin
            iss_op1_d = sel_e.op1_val;
            iss_op2_d = sel_e.op2_val;
            iss_f3_d  = sel_e.funct3;
            iss_ext_d = sel_e.alu_ext;
            iss_tag_d = sel_e.dest_tag;
         end
      end
   end

   // Issue register feeding the combinational ALU.
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_vld_q <= 1'b0;
         iss_op1_q <= '0;
         iss_op2_q <= '0;
         iss_f3_q  <= '0;
         iss_ext_q <= '0;
         iss_tag_q <= '0;
      end else begin
         iss_vld_q <= iss_vld_d;
         iss_op1_q <= iss_op1_d;
         iss_op2_q <= iss_op2_d;
         iss_f3_q  <= iss_f3_d;
         iss_ext_q <= iss_ext_d;
         iss_tag_q <= iss_tag_d;
      end
   end

   assign bus.iss_tag_valid = iss_vld_q;
   assign bus.iss_op1       = iss_op1_q;
   assign bus.iss_op2       = iss_op2_q;
   assign bus.iss_funct3    = iss_f3_q;
   assign bus.iss_alu_ext   = iss_ext_q;
   assign bus.iss_tag       = iss_tag_q;

endmodule

// File: tb/tb_alu_rsv_station.sv
// Bench for alu_rsv_station: directed scenarios plus random traffic, with a
// slot-level reference model feeding a per-edge expectation queue.
module tb_alu_rsv_station;
   import alu_rs_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 6;
   localparam int XLEN  = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_rsv_station_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

   alu_rsv_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic             ready;
      int               cnt;
      logic             iv;
      logic [XLEN-1:0]  op1;
      logic [XLEN-1:0]  op2;
      logic [2:0]       f3;
      logic [2:0]       ext;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: slots with explicit fields and a dispatch sequence number.
   bit               m_v  [DEPTH];
   bit               m_r1 [DEPTH];
   bit               m_r2 [DEPTH];
   logic [TAG_W-1:0] m_t1 [DEPTH];
   logic [TAG_W-1:0] m_t2 [DEPTH];
   logic [XLEN-1:0]  m_v1 [DEPTH];
   logic [XLEN-1:0]  m_v2 [DEPTH];
   logic [2:0]       m_f3 [DEPTH];
   logic [2:0]       m_ext[DEPTH];
   logic [TAG_W-1:0] m_dst[DEPTH];
   int               m_seq[DEPTH];
   int               seq_ctr = 0;
   logic             m_iv  = 1'b0;
   logic [XLEN-1:0]  m_op1 = '0;
   logic [XLEN-1:0]  m_op2 = '0;
   logic [2:0]       m_if3 = '0;
   logic [2:0]       m_iext = '0;
   logic [TAG_W-1:0] m_itag = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
   endtask

   function automatic int occupied();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) if (m_v[i]) c++;
      return c;
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      int   sel, slot;
      exp_t e;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
         m_iv = 0; m_op1 = '0; m_op2 = '0; m_if3 = '0; m_iext = '0; m_itag = '0;
      end else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
         m_iv = 0;
      end else begin
         slot = -1;
         if (bus.disp_valid && occupied() < DEPTH) begin
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) slot = i;
         end
         sel = -1;
         for (int i = 0; i < DEPTH; i++) begin
            if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_SEL_EN
               if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
               if (sel < 0) sel = i;
`endif
            end
         end
         if (!bus.iss_stall) begin
            m_iv = (sel >= 0);
            if (sel >= 0) begin
               m_op1 = m_v1[sel]; m_op2 = m_v2[sel]; m_if3 = m_f3[sel];
               m_iext = m_ext[sel]; m_itag = m_dst[sel];
               m_v[sel] = 0;
            end
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (m_v[i] && bus.cdb_valid) begin
               if (!m_r1[i] && m_t1[i] == bus.cdb_tag) begin m_r1[i] = 1; m_v1[i] = bus.cdb_data; end
               if (!m_r2[i] && m_t2[i] == bus.cdb_tag) begin m_r2[i] = 1; m_v2[i] = bus.cdb_data; end
            end
         end
         if (slot >= 0) begin
            m_v[slot]   = 1;
            m_t1[slot]  = bus.disp_op1_tag;
            m_t2[slot]  = bus.disp_op2_tag;
            m_r1[slot]  = bus.disp_op1_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_op1_tag);
            m_r2[slot]  = bus.disp_op2_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_op2_tag);
            m_v1[slot]  = bus.disp_op1_rdy ? bus.disp_op1_val : bus.cdb_data;
            m_v2[slot]  = bus.disp_op2_rdy ? bus.disp_op2_val : bus.cdb_data;
            m_f3[slot]  = bus.disp_funct3;
            m_ext[slot] = bus.disp_alu_ext;
            m_dst[slot] = bus.disp_dest_tag;
            m_seq[slot] = seq_ctr++;
         end
      end
      e.cnt = occupied(); e.ready = (e.cnt < DEPTH);
      e.iv = m_iv; e.op1 = m_op1; e.op2 = m_op2; e.f3 = m_if3; e.ext = m_iext; e.tag = m_itag;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.disp_valid = 0; bus.cdb_valid = 0; bus.iss_stall = 0; bus.flush = 0;
   endtask

   task automatic disp(input bit r1, input int t1, input int v1,
                       input bit r2, input int t2, input int v2,
                       input int f3, input int ext, input int dest);
      bus.disp_valid   = 1;
      bus.disp_op1_rdy = r1; bus.disp_op1_tag = TAG_W'(t1); bus.disp_op1_val = XLEN'(v1);
      bus.disp_op2_rdy = r2; bus.disp_op2_tag = TAG_W'(t2); bus.disp_op2_val = XLEN'(v2);
      bus.disp_funct3  = 3'(f3); bus.disp_alu_ext = 3'(ext); bus.disp_dest_tag = TAG_W'(dest);
   endtask

   task automatic cdb(input int tag, input int data);
      bus.cdb_valid = 1; bus.cdb_tag = TAG_W'(tag); bus.cdb_data = XLEN'(data);
   endtask

   // Monitor: every negedge compares the DUT outputs with the next expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("mon_count",   64'(bus.count),         64'(e.cnt));
         chk("mon_ready",   64'(bus.disp_ready),    64'(e.ready));
         chk("mon_iss_vld", 64'(bus.iss_tag_valid), 64'(e.iv));
         chk("mon_iss_op1", 64'(bus.iss_op1),       64'(e.op1));
         chk("mon_iss_op2", 64'(bus.iss_op2),       64'(e.op2));
         chk("mon_iss_f3",  64'(bus.iss_funct3),    64'(e.f3));
         chk("mon_iss_ext", 64'(bus.iss_alu_ext),   64'(e.ext));
         chk("mon_iss_tag", 64'(bus.iss_tag),       64'(e.tag));
      end
   end

   initial begin
      rst = 1;
      idle();
      disp(1, 0, 0, 1, 0, 0, 0, 0, 0);
      bus.disp_valid = 0;
      bus.cdb_tag = '0; bus.cdb_data = '0;
      tick(); tick();
      rst = 0;
      chk("rst_count", 64'(bus.count), 0);
      chk("rst_ready", 64'(bus.disp_ready), 1);
      chk("rst_iv",    64'(bus.iss_tag_valid), 0);
      chk("rst_op1",   64'(bus.iss_op1), 0);
      chk("rst_tag",   64'(bus.iss_tag), 0);

      // Ready ADD: issues two edges after dispatch
      disp(1, 0, 5, 1, 0, 7, 0, ALU_EXT_R, 3); tick();
      idle(); tick();
      chk("add_iv",  64'(bus.iss_tag_valid), 1);
      chk("add_op1", 64'(bus.iss_op1), 5);
      chk("add_op2", 64'(bus.iss_op2), 7);
      chk("add_tag", 64'(bus.iss_tag), 3);
      chk("add_cnt", 64'(bus.count), 0);
      tick();

      // Wakeup from the CDB
      disp(1, 0, 'h11, 0, 9, 0, 2, ALU_EXT_R, 4); tick();
      idle(); tick();
      cdb(9, 'h100); tick();
      idle(); tick();
      chk("wake_iv",  64'(bus.iss_tag_valid), 1);
      chk("wake_op2", 64'(bus.iss_op2), 'h100);
      chk("wake_tag", 64'(bus.iss_tag), 4);
      tick();

      // Dispatch-cycle bypass
      disp(0, 12, 0, 1, 0, 3, 5, ALU_EXT_SUB, 5); cdb(12, 'hAB); tick();
      idle(); tick();
      chk("byp_iv",  64'(bus.iss_tag_valid), 1);
      chk("byp_op1", 64'(bus.iss_op1), 'hAB);
      chk("byp_tag", 64'(bus.iss_tag), 5);
      tick();

      // Fill, drop an extra dispatch, wake entries 0 and 3 together
      disp(0, 20, 0, 1, 0, 1, 0, ALU_EXT_R, 10); tick();
      disp(0, 21, 0, 1, 0, 2, 0, ALU_EXT_R, 11); tick();
      disp(0, 22, 0, 1, 0, 3, 0, ALU_EXT_R, 12); tick();
      disp(0, 20, 0, 1, 0, 4, 0, ALU_EXT_R, 13); tick();
      chk("full_ready", 64'(bus.disp_ready), 0);
      disp(1, 0, 9, 1, 0, 9, 0, ALU_EXT_R, 14); tick();
      chk("full_cnt", 64'(bus.count), 4);
      idle(); cdb(20, 'h55); tick();
      idle(); tick();
      chk("first_tag", 64'(bus.iss_tag), 10);
      chk("first_op1", 64'(bus.iss_op1), 'h55);
      tick();
      chk("second_tag", 64'(bus.iss_tag), 13);
      cdb(21, 1); tick();
      cdb(22, 2); tick();
      idle(); tick(); tick(); tick();
      chk("drain_cnt", 64'(bus.count), 0);

      // Stall holds the issue register and the waiting entry
      disp(1, 0, 1, 1, 0, 2, 1, ALU_EXT_JAL, 30); tick();
      disp(1, 0, 3, 1, 0, 4, 3, ALU_EXT_BRANCH, 31); tick();
      idle(); bus.iss_stall = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_tag", 64'(bus.iss_tag), 30);
         chk("stall_cnt", 64'(bus.count), 1);
      end
      bus.iss_stall = 0; tick();
      chk("release_tag", 64'(bus.iss_tag), 31);
      chk("release_cnt", 64'(bus.count), 0);
      tick();

      // Flush with three entries and a valid issue register
      disp(1, 0, 1, 1, 0, 1, 0, ALU_EXT_UPPER, 40); tick();
      disp(0, 50, 0, 1, 0, 1, 0, ALU_EXT_R, 41); tick();
      disp(0, 51, 0, 1, 0, 1, 0, ALU_EXT_R, 42); bus.iss_stall = 1; tick();
      disp(0, 52, 0, 1, 0, 1, 0, ALU_EXT_R, 43); tick();
      chk("preflush_cnt", 64'(bus.count), 3);
      chk("preflush_iv",  64'(bus.iss_tag_valid), 1);
      disp(1, 0, 1, 1, 0, 1, 0, ALU_EXT_R, 44); bus.iss_stall = 0; bus.flush = 1; tick();
      chk("flush_cnt", 64'(bus.count), 0);
      chk("flush_iv",  64'(bus.iss_tag_valid), 0);
      idle(); tick();
      chk("postflush_cnt", 64'(bus.count), 0);

      // Random traffic
      for (int n = 0; n < 2500; n++) begin
         rst = ($urandom_range(0, 999) < 5);
         bus.flush     = ($urandom_range(0, 99) < 2);
         bus.iss_stall = ($urandom_range(0, 99) < 20);
         bus.cdb_valid = ($urandom_range(0, 99) < 50);
         bus.cdb_tag   = TAG_W'($urandom_range(0, 15));
         bus.cdb_data  = $urandom;
         disp($urandom_range(0, 1), $urandom_range(0, 15), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
              $urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 63));
         bus.disp_valid = ($urandom_range(0, 99) < 60);
         tick();
      end
      rst = 0; idle(); tick();

      @(negedge clk); #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
